// File: rtl/median_frame_rebuilder_if.sv
// Stream bundle between the median filter stage, the frame rebuilder and the display path.
// The source side drives vsync/din/din_vld; the rebuilder drives the raster outputs and status.
interface median_frame_rebuilder_if #(
    parameter int DW = 8
) ();
    logic          vsync;
    logic [DW-1:0] din;
    logic          din_vld;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_sof;
    logic          dout_sol;
    logic          dout_eol;
    logic          dout_eof;
    logic          ovf;
    logic          frame_err;
    logic          busy;

    modport master (
        output vsync, din, din_vld,
        input  dout, dout_vld, dout_sof, dout_sol, dout_eol, dout_eof, ovf, frame_err, busy
    );

    modport slave (
        input  vsync, din, din_vld,
        output dout, dout_vld, dout_sof, dout_sol, dout_eol, dout_eof, ovf, frame_err, busy
    );
endinterface

// File: rtl/median_frame_rebuilder.sv
// Rebuilds a full IMG_W x IMG_H raster from the border-less median stream, padding the
// one-pixel frame border with BORDER_VAL and tagging sof/sol/eol/eof on the output pixels.
module median_frame_rebuilder #(
    parameter int            IMG_W      = 640,
    parameter int            IMG_H      = 480,
    parameter int            DW         = 8,
    parameter logic [DW-1:0] BORDER_VAL = {DW{1'b0}},
    parameter int            FIFO_AW    = 4
) (
    input logic                   sclk,
    input logic                   s_rst,
    median_frame_rebuilder_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = FIFO_AW + 1;

    localparam logic [CW-1:0] COL_ZERO      = CW'(0);
    localparam logic [CW-1:0] COL_ONE       = CW'(1);
    localparam logic [CW-1:0] COL_BODY_LAST = CW'(IMG_W - 2);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ZERO      = RW'(0);
    localparam logic [RW-1:0] ROW_ONE       = RW'(1);
    localparam logic [RW-1:0] ROW_BODY_LAST = RW'(IMG_H - 2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PTR_ONE       = PW'(1);
    localparam logic [PW-1:0] PTR_WRAP      = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TOP    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_BODY   = 3'd3,
        ST_RIGHT  = 3'd4,
        ST_BOTTOM = 3'd5
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [DW-1:0] mem_r [2**FIFO_AW];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic          fifo_empty_s, fifo_full_s, abort_s, wr_en_s, rd_en_s;
    logic          emit_s, sof_s, sol_s, eol_s, eof_s;
    logic [DW-1:0] pix_s;
    logic [DW-1:0] dout_r;
    logic          dout_vld_r, dout_sof_r, dout_sol_r, dout_eol_r, dout_eof_r;
    logic          ovf_r, frame_err_r, busy_r;

    // A vsync during a frame flushes the FIFO, so the write of that same cycle is discarded.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = ((wr_ptr_r ^ rd_ptr_r) == PTR_WRAP);
    assign abort_s      = bus.vsync && (state_r != ST_IDLE);
    assign wr_en_s      = bus.din_vld && !fifo_full_s && !abort_s;

    // FIFO storage
    always_ff @(posedge sclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= bus.din;
        end
    end

    // FIFO pointers
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (abort_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // FSM state register
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next-state logic; any vsync (re)starts a frame at the top border
    always_comb begin
        state_nxt_s = state_r;
        if (bus.vsync) begin
            state_nxt_s = ST_TOP;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_IDLE;
                ST_TOP:    state_nxt_s = (col_r == COL_LAST) ? ST_LEFT : ST_TOP;
                ST_LEFT:   state_nxt_s = ST_BODY;
                ST_BODY:   state_nxt_s = (!fifo_empty_s && col_r == COL_BODY_LAST) ? ST_RIGHT : ST_BODY;
                ST_RIGHT:  state_nxt_s = (row_r == ROW_BODY_LAST) ? ST_BOTTOM : ST_LEFT;
                ST_BOTTOM: state_nxt_s = (col_r == COL_LAST) ? ST_IDLE : ST_BOTTOM;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: pixel choice and markers for the pixel emitted this cycle
    always_comb begin
        emit_s  = 1'b0;
        rd_en_s = 1'b0;
        sof_s   = 1'b0;
        sol_s   = 1'b0;
        eol_s   = 1'b0;
        eof_s   = 1'b0;
        pix_s   = BORDER_VAL;
        if (!bus.vsync) begin
            case (state_r)
                ST_TOP: begin
                    emit_s = 1'b1;
                    sof_s  = (col_r == COL_ZERO);
                    sol_s  = (col_r == COL_ZERO);
                    eol_s  = (col_r == COL_LAST);
                end
                ST_LEFT: begin
                    emit_s = 1'b1;
                    sol_s  = 1'b1;
                end
                ST_BODY: begin
                    emit_s  = !fifo_empty_s;
                    rd_en_s = !fifo_empty_s;
                    pix_s   = mem_r[rd_ptr_r[FIFO_AW-1:0]];
                end
                ST_RIGHT: begin
                    emit_s = 1'b1;
                    eol_s  = 1'b1;
                end
                ST_BOTTOM: begin
                    emit_s = 1'b1;
                    sol_s  = (col_r == COL_ZERO);
                    eol_s  = (col_r == COL_LAST);
                    eof_s  = (col_r == COL_LAST);
                end
                default: emit_s = 1'b0;
            endcase
        end else begin
            emit_s = 1'b0;
        end
    end

    // Raster position counters; BODY holds position while the FIFO is empty
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (bus.vsync) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else begin
            case (state_r)
                ST_TOP: begin
                    if (col_r == COL_LAST) begin
                        col_r <= COL_ZERO;
                        row_r <= ROW_ONE;
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                ST_LEFT: col_r <= COL_ONE;
                ST_BODY: begin
                    if (rd_en_s) col_r <= (col_r == COL_BODY_LAST) ? COL_LAST : col_r + COL_ONE;
                end
                ST_RIGHT: begin
                    col_r <= COL_ZERO;
                    row_r <= (row_r == ROW_BODY_LAST) ? ROW_LAST : row_r + ROW_ONE;
                end
                ST_BOTTOM: begin
                    if (col_r == COL_LAST) begin
                        col_r <= COL_ZERO;
                        row_r <= ROW_ZERO;
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                default: begin
                    col_r <= col_r;
                    row_r <= row_r;
                end
            endcase
        end
    end

    // Registered pixel, markers and status outputs
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            dout_r      <= {DW{1'b0}};
            dout_vld_r  <= 1'b0;
            dout_sof_r  <= 1'b0;
            dout_sol_r  <= 1'b0;
            dout_eol_r  <= 1'b0;
            dout_eof_r  <= 1'b0;
            ovf_r       <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            dout_r      <= emit_s ? pix_s : {DW{1'b0}};
            dout_vld_r  <= emit_s;
            dout_sof_r  <= emit_s && sof_s;
            dout_sol_r  <= emit_s && sol_s;
            dout_eol_r  <= emit_s && eol_s;
            dout_eof_r  <= emit_s && eof_s;
            frame_err_r <= abort_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (bus.vsync)                        ovf_r <= 1'b0;
            else if (bus.din_vld && fifo_full_s)  ovf_r <= 1'b1;
            else                                  ovf_r <= ovf_r;
        end
    end

    assign bus.dout      = dout_r;
    assign bus.dout_vld  = dout_vld_r;
    assign bus.dout_sof  = dout_sof_r;
    assign bus.dout_sol  = dout_sol_r;
    assign bus.dout_eol  = dout_eol_r;
    assign bus.dout_eof  = dout_eof_r;
    assign bus.ovf       = ovf_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_median_frame_rebuilder.sv
// Directed bench for median_frame_rebuilder on a 6x5 raster: expected pixels are queued
// when a frame is started and compared as the rebuilder emits them.
module tb_median_frame_rebuilder;
    localparam int IMG_W = 6;
    localparam int IMG_H = 5;
    localparam int DW    = 8;

    logic sclk  = 1'b0;
    logic s_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    logic [11:0] sb_q [$];

    median_frame_rebuilder_if #(.DW(DW)) bus_if ();

    median_frame_rebuilder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .BORDER_VAL(8'd0), .FIFO_AW(4)
    ) dut (
        .sclk (sclk),
        .s_rst(s_rst),
        .bus  (bus_if.slave)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #2;
    endtask

    task automatic push_frame(input int base, input int n_max);
        int n = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (n < n_max) begin
                    logic       border;
                    logic [7:0] d;
                    border = (r == 0) || (r == IMG_H - 1) || (c == 0) || (c == IMG_W - 1);
                    d = border ? 8'd0 : 8'(base + (r - 1) * (IMG_W - 2) + (c - 1));
                    sb_q.push_back({d, 1'(r == 0 && c == 0), 1'(c == 0), 1'(c == IMG_W - 1),
                                    1'(r == IMG_H - 1 && c == IMG_W - 1)});
                    n++;
                end
            end
        end
    endtask

    task automatic feed(input int base, input int gap);
        for (int i = 0; i < 12; i++) begin
            bus_if.din     = 8'(base + i);
            bus_if.din_vld = 1'b1;
            step();
            bus_if.din_vld = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic vsync_pulse();
        bus_if.vsync = 1'b1;
        step();
        bus_if.vsync = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb_q.size() != 0 || bus_if.busy) && t < 400) begin
            step();
            t++;
        end
        chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic wait_outputs(input int n);
        int start = out_cnt;
        int t = 0;
        while (out_cnt - start < n && t < 300) begin
            @(negedge sclk);
            #1;
            t++;
        end
        chk("out_count_reached", 32'(out_cnt - start), 32'(n));
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge sclk) begin
        if (bus_if.dout_vld === 1'b1) begin
            out_cnt++;
            chk("unexpected_output", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                logic [11:0] exp_v;
                exp_v = sb_q.pop_front();
                chk("pixel_markers", 32'({bus_if.dout, bus_if.dout_sof, bus_if.dout_sol,
                                          bus_if.dout_eol, bus_if.dout_eof}), 32'(exp_v));
            end
        end else begin
            chk("markers_without_vld", 32'({bus_if.dout_sof, bus_if.dout_sol,
                                            bus_if.dout_eol, bus_if.dout_eof}), 32'd0);
        end
    end

    initial begin
        bus_if.vsync   = 1'b0;
        bus_if.din     = 8'd0;
        bus_if.din_vld = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_vld", 32'(bus_if.dout_vld), 32'd0);
        chk("rst_dout", 32'(bus_if.dout), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_flags", 32'({bus_if.ovf, bus_if.frame_err}), 32'd0);
        s_rst = 1'b0;

        // idle for 100 cycles without vsync
        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 25 == 24) begin
                chk("idle_vld", 32'(bus_if.dout_vld), 32'd0);
                chk("idle_status", 32'({bus_if.busy, bus_if.ovf, bus_if.frame_err}), 32'd0);
            end
        end

        // full frame, pixels back to back
        push_frame(1, 30);
        vsync_pulse();
        chk("t2_busy", 32'(bus_if.busy), 32'd1);
        chk("t2_no_frame_err", 32'(bus_if.frame_err), 32'd0);
        feed(1, 0);
        drain("t2");

        // sparse input, one pixel every 4th cycle
        push_frame(1, 30);
        vsync_pulse();
        feed(1, 3);
        drain("t3");
        chk("t3_ovf", 32'(bus_if.ovf), 32'd0);

        // overflow while idle: 16 accepted, 17th onwards dropped
        for (int i = 0; i < 20; i++) begin
            bus_if.din     = 8'(101 + i);
            bus_if.din_vld = 1'b1;
            step();
            if (i == 15) chk("t4_ovf_at_16", 32'(bus_if.ovf), 32'd0);
            if (i == 16) chk("t4_ovf_at_17", 32'(bus_if.ovf), 32'd1);
        end
        bus_if.din_vld = 1'b0;
        chk("t4_ovf_sticky", 32'(bus_if.ovf), 32'd1);
        push_frame(101, 30);
        vsync_pulse();
        chk("t4_ovf_cleared", 32'(bus_if.ovf), 32'd0);
        chk("t4_no_frame_err", 32'(bus_if.frame_err), 32'd0);
        drain("t4");

        // abort at output #10 using the four leftover pixels 113..116
        push_frame(113, 10);
        vsync_pulse();
        wait_outputs(10);
        push_frame(201, 30);
        bus_if.vsync = 1'b1;
        step();
        bus_if.vsync = 1'b0;
        chk("t5_frame_err_pulse", 32'(bus_if.frame_err), 32'd1);
        chk("t5_busy", 32'(bus_if.busy), 32'd1);
        chk("t5_ovf", 32'(bus_if.ovf), 32'd0);
        step();
        chk("t5_frame_err_end", 32'(bus_if.frame_err), 32'd0);
        feed(201, 0);
        drain("t5");

        // reset in the middle of the body rows
        push_frame(51, 30);
        vsync_pulse();
        feed(51, 0);
        wait_outputs(3);
        s_rst = 1'b1;
        sb_q.delete();
        #1;
        chk("t6_rst_vld", 32'(bus_if.dout_vld), 32'd0);
        chk("t6_rst_busy", 32'(bus_if.busy), 32'd0);
        step();
        chk("t6_rst_outputs", 32'({bus_if.dout, bus_if.dout_vld, bus_if.busy, bus_if.ovf,
                                   bus_if.frame_err}), 32'd0);
        s_rst = 1'b0;
        repeat (10) step();
        chk("t6_no_restart", 32'({bus_if.dout_vld, bus_if.busy}), 32'd0);
        push_frame(71, 30);
        vsync_pulse();
        feed(71, 0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
